// File: rtl/mem_bridge.sv
// ============================================================================
// mem_bridge
// ----------------------------------------------------------------------------
// Bridges the 6502 core memory port to an external asynchronous SRAM/ROM bus.
// Each accepted request performs one byte read or write with an IDLE -> SETUP
// -> ACCESS(WAIT_STATES+1) -> DONE sequence. The active-low strobes come
// straight from flops, so they are glitch-free. Read data is registered, and a
// one-cycle cpu_done pulse marks each completed transfer.
//
// Optional feature: define MEM_BRIDGE_RESET_VECTOR_EN to serve reads of
// 16'hFFFC/16'hFFFD from RESET_VECTOR. Those reads keep mem_ce_n/mem_oe_n high.
//
// Parameters:
//   WAIT_STATES  - extra ACCESS cycles per transfer (0..15)
//   RESET_VECTOR - vector served when MEM_BRIDGE_RESET_VECTOR_EN is defined
//
// Ports:
//   clk, reset            - system clock (rising edge), async active-high reset
//   cpu_addr/cpu_wr_data  - request address / write data
//   cpu_we, cpu_req       - 1 = write; request strobe (sampled while ready)
//   cpu_ready             - bridge accepts a request this cycle
//   cpu_done, cpu_rd_data - completion pulse, registered read data
//   mem_addr/mem_wr_data  - registered external address / write data
//   mem_rd_data           - external read data
//   mem_ce_n/oe_n/we_n    - active-low external strobes
// ============================================================================
module mem_bridge #(
    parameter int unsigned WAIT_STATES  = 1,
    parameter logic [15:0] RESET_VECTOR = 16'h0200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wr_data,
    input  logic        cpu_we,
    input  logic        cpu_req,
    output logic        cpu_ready,
    output logic        cpu_done,
    output logic [7:0]  cpu_rd_data,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wr_data,
    input  logic [7:0]  mem_rd_data,
    output logic        mem_ce_n,
    output logic        mem_oe_n,
    output logic        mem_we_n
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic        r_vec;
    logic [15:0] r_addr;
    logic [7:0]  r_wr_data;
    logic [7:0]  r_rd_data;
    logic        r_ce_n;
    logic        r_oe_n;
    logic        r_we_n;

    logic [1:0]  w_next_state;
    logic        w_ready;
    logic        w_accept;
    logic        w_last;
    logic        w_hit;
    logic        w_next_we;
    logic        w_next_vec;
    logic        w_bus_active;
    logic [7:0]  w_vec_byte;

    assign w_ready  = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept = cpu_req && w_ready;
    assign w_last   = (r_state == S_ACCESS) && (r_cnt == 4'd0);

`ifdef MEM_BRIDGE_RESET_VECTOR_EN
    // Only reads of the 6502 reset vector pair (16'hFFFC/16'hFFFD) are served
    // locally. Writes to those addresses still go to the bus.
    assign w_hit = !cpu_we && (cpu_addr[15:1] == 15'h7FFE);
`else
    assign w_hit = 1'b0;
`endif

    assign w_vec_byte = r_addr[0] ? RESET_VECTOR[15:8] : RESET_VECTOR[7:0];

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next_state = S_SETUP;
            S_SETUP:  w_next_state = S_ACCESS;
            S_ACCESS: if (r_cnt == 4'd0) w_next_state = S_DONE;
            S_DONE:   w_next_state = w_accept ? S_SETUP : S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // The strobe flops are loaded from the next-state decode. This keeps them
    // cycle-aligned with r_state while still driving the pins from registers.
    assign w_next_we    = w_accept ? cpu_we : r_we;
    assign w_next_vec   = w_accept ? w_hit  : r_vec;
    assign w_bus_active = (w_next_state == S_SETUP) || (w_next_state == S_ACCESS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_vec     <= 1'b0;
            r_addr    <= '0;
            r_wr_data <= '0;
            r_rd_data <= '0;
            r_ce_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_we_n    <= 1'b1;
        end else begin
            r_state <= w_next_state;

            if (w_accept) begin
                r_addr    <= cpu_addr;
                r_wr_data <= cpu_wr_data;
                r_we      <= cpu_we;
                r_vec     <= w_hit;
            end

            // WAIT_STATES is limited to 0..15 by the 4-bit counter.
            if (r_state == S_SETUP) begin
                r_cnt <= 4'(WAIT_STATES);
            end else if ((r_state == S_ACCESS) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_last && !r_we) begin
                r_rd_data <= r_vec ? w_vec_byte : mem_rd_data;
            end

            r_ce_n <= !w_bus_active || w_next_vec;
            r_oe_n <= !(w_bus_active && !w_next_we) || w_next_vec;
            r_we_n <= !((w_next_state == S_ACCESS) && w_next_we);
        end
    end

    assign cpu_ready   = w_ready;
    assign cpu_done    = (r_state == S_DONE);
    assign cpu_rd_data = r_rd_data;
    assign mem_addr    = r_addr;
    assign mem_wr_data = r_wr_data;
    assign mem_ce_n    = r_ce_n;
    assign mem_oe_n    = r_oe_n;
    assign mem_we_n    = r_we_n;

endmodule

// File: doc/mem_bridge.md
# mem_bridge

Bus bridge between the 6502 core's memory port and an external asynchronous SRAM/ROM bus. It accepts one byte read or write per request from the core and generates chip-enable, output-enable and write-enable strobes with a programmable number of wait states. It returns registered read data together with a one-cycle completion pulse. The block sits directly upstream of the core's `rd_data` input and directly downstream of its `address` output.

## Interface
- `WAIT_STATES`, default 1: extra ACCESS cycles per transfer. Legal range is 0–15, held in a 4-bit counter.
- `RESET_VECTOR`, default 16'h0200: vector returned when `MEM_BRIDGE_RESET_VECTOR_EN` is defined. Unused otherwise.

Ports:
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cpu_addr` in 16: request address.
- `cpu_wr_data` in 8: write data.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_req` in 1: request strobe. Sampled only while `cpu_ready` = 1.
- `cpu_ready` out 1: bridge can accept a request this cycle.
- `cpu_done` out 1: one-cycle pulse marking transfer complete. `cpu_rd_data` is valid while it is high.
- `cpu_rd_data` out 8: registered read data. Holds its value until the next read completes.
- `mem_addr` out 16: registered external address.
- `mem_wr_data` out 8: registered external write data.
- `mem_rd_data` in 8: external read data.
- `mem_ce_n`, `mem_oe_n`, `mem_we_n` out 1 each: active-low strobes.

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE.
- `cpu_ready` = (state is IDLE or DONE).
- Accept rule: on an edge with `cpu_req` = 1 and `cpu_ready` = 1:
  - Latch `cpu_addr` into `mem_addr` and `cpu_wr_data` into `mem_wr_data`, and record `cpu_we`.
  - Next state is SETUP.
- IDLE: no request goes to IDLE; a request goes to SETUP.
- SETUP (1 cycle):
  - `mem_ce_n` = 0.
  - `mem_oe_n` = 0 for a read, 1 for a write.
  - `mem_we_n` = 1.
  - Load wait counter = `WAIT_STATES`. Go to ACCESS.
- ACCESS (`WAIT_STATES`+1 cycles):
  - `mem_ce_n` = 0.
  - Read: `mem_oe_n` = 0. Write: `mem_we_n` = 0.
  - Counter decrements each edge.
  - On the edge where counter = 0: a read captures `mem_rd_data` into `cpu_rd_data`; then go to DONE.
- DONE (1 cycle):
  - All strobes = 1. `mem_addr` and `mem_wr_data` are held, giving address/data hold after `mem_we_n` rises.
  - `cpu_done` = 1.
  - A request accepted here goes to SETUP; otherwise go to IDLE.
- Strobes are never low in IDLE or DONE. `mem_oe_n` and `mem_we_n` are never low simultaneously.
- `cpu_req` while not ready is ignored and not queued.
- `cpu_addr`, `cpu_we` and `cpu_wr_data` changing after acceptance have no effect on the transfer in flight.

## Timing
- Reset values, applied immediately on `reset` assertion regardless of `clk`:
  - state = IDLE.
  - `cpu_ready` = 1, `cpu_done` = 0, `cpu_rd_data` = 8'h00.
  - `mem_addr` = 16'h0000, `mem_wr_data` = 8'h00.
  - `mem_ce_n` = `mem_oe_n` = `mem_we_n` = 1.
- Reset mid-transfer: the transfer is aborted. No `cpu_done` is produced and `cpu_rd_data` is not updated except by the clear to 8'h00.
- Latency: `cpu_done` goes high `WAIT_STATES`+2 edges after the accepting edge (2 edges at `WAIT_STATES`=0).
- Throughput: with back-to-back acceptance in DONE, one transfer completes every `WAIT_STATES`+3 cycles.
- Strobe outputs are registered and decoded from state only, so they are glitch-free.

## Configuration
- `MEM_BRIDGE_RESET_VECTOR_EN` defined:
  - Reads of 16'hFFFC return `RESET_VECTOR[7:0]`; reads of 16'hFFFD return `RESET_VECTOR[15:8]`.
  - The FSM sequence and latency are unchanged, but `mem_ce_n` and `mem_oe_n` stay 1 for the whole transfer.
  - Writes to these addresses go to the external bus normally.
- Macro undefined: every address, including 16'hFFFC/16'hFFFD, goes to the external bus.

## Test plan
- Reset values: assert `reset` asynchronously mid-cycle → all outputs take their reset values before the next edge, and `cpu_ready` = 1.
- Read, `WAIT_STATES`=0: request read of 16'h1234 with `mem_rd_data` = 8'hA5.
  - `mem_ce_n`/`mem_oe_n` low for exactly 2 cycles (SETUP + ACCESS).
  - `cpu_done` pulses 2 edges after acceptance with `cpu_rd_data` = 8'hA5.
- Write, `WAIT_STATES`=3: request write of 8'h5A to 16'h0200.
  - `mem_we_n` low for exactly 4 cycles and never during SETUP.
  - `mem_oe_n` stays 1.
  - `mem_addr`/`mem_wr_data` are stable from SETUP through DONE.
  - `cpu_done` pulses after 5 edges.
- Back-to-back: hold `cpu_req` high for reads of 16'h0010 then 16'h0011 (`WAIT_STATES`=1) → second SETUP starts the cycle after the first DONE with no IDLE cycle in between, and `cpu_req` in SETUP/ACCESS is ignored.
- Reset mid-ACCESS of a write → `mem_we_n` returns to 1 immediately, no `cpu_done` occurs, and the FSM is in IDLE after release.
- Vector override, macro defined, `RESET_VECTOR` = 16'h0200: reads of 16'hFFFC/16'hFFFD return 8'h00/8'h02 with `mem_ce_n` held at 1. With the macro undefined, `mem_rd_data` is returned and strobes toggle.
